// File: rtl/lsu_pkg.sv
// ============================================================================
// Module  : lsu_pkg
// Brief   : Shared size encodings, FSM state enum and lane-mask helper.
// Revision: 1.0
// ============================================================================
`default_nettype none

package lsu_pkg;

  localparam logic [1:0] c_SIZE_BYTE = 2'b00;
  localparam logic [1:0] c_SIZE_HALF = 2'b01;
  localparam logic [1:0] c_SIZE_WORD = 2'b10;
  localparam logic [1:0] c_SIZE_ILL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC0 = 2'd1,
    ST_ACC1 = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_t;

  // Lane mask of an access at offset 0; an empty mask marks an illegal size.
  function automatic logic [3:0] size_mask(input logic [1:0] size);
    case (size)
      c_SIZE_BYTE: size_mask = 4'b0001;
      c_SIZE_HALF: size_mask = 4'b0011;
      c_SIZE_WORD: size_mask = 4'b1111;
      default:     size_mask = 4'b0000;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// ============================================================================
// Module  : lsu_align
// Brief   : Lane masks, store-data rotation and load merge/extension.
// Revision: 1.0
// ============================================================================
`default_nettype none

module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  i_offset,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_w0,
  input  logic [31:0] i_w1,
  output logic [3:0]  o_mask0,
  output logic [3:0]  o_mask1,
  output logic        o_misaligned,
  output logic        o_size_illegal,
  output logic [31:0] o_wdata_rot,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_lanes;
  logic [4:0]  w_shamt;
  logic [63:0] w_wdup;
  logic [63:0] w_rdwin;
  logic [31:0] w_raw;

  assign w_shamt = {i_offset, 3'b000};
  // Lanes past 3 spill into the next word, so the upper nibble is the ACC1 mask.
  assign w_lanes = {4'b0000, size_mask(i_size)} << i_offset;

  assign o_mask0        = w_lanes[3:0];
  assign o_mask1        = w_lanes[7:4];
  assign o_misaligned   = |w_lanes[7:4];
  assign o_size_illegal = (i_size == c_SIZE_ILL);

  assign w_wdup      = {i_wdata, i_wdata} << w_shamt;
  assign o_wdata_rot = w_wdup[63:32];

  assign w_rdwin = {i_w1, i_w0} >> w_shamt;
  assign w_raw   = w_rdwin[31:0];

  always_comb begin
    o_rdata = w_raw;
    case (i_size)
      c_SIZE_BYTE: o_rdata = {{24{~i_unsigned & w_raw[7]}}, w_raw[7:0]};
      c_SIZE_HALF: o_rdata = {{16{~i_unsigned & w_raw[15]}}, w_raw[15:0]};
      default:     o_rdata = w_raw;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// Module  : load_store_unit
// Brief   : Byte/half/word load-store unit onto a word RAM, splitting or
//           rejecting word-crossing accesses.
// Revision: 1.0
// ============================================================================
`default_nettype none

module load_store_unit
  import lsu_pkg::*;
#(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_a,
  output logic [31:0] mem_di,
  output logic [3:0]  mem_m,
  output logic        mem_we,
  input  logic [31:0] mem_do
);

  lsu_state_t  r_state;
  logic        r_req_ready;
  logic        r_we;
  logic [1:0]  r_off;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [31:0] r_w0;
  logic        r_resp_valid;
  logic [31:0] r_resp_rdata;
  logic        r_resp_err;
  logic [31:0] r_mem_a;
  logic [31:0] r_mem_di;
  logic [3:0]  r_mem_m;
  logic        r_mem_we;

  logic        w_idle;
  logic [1:0]  w_off;
  logic [1:0]  w_size;
  logic        w_unsigned;
  logic [31:0] w_w0;
  logic [3:0]  w_mask0;
  logic [3:0]  w_mask1;
  logic        w_misaligned;
  logic        w_size_ill;
  logic [31:0] w_wdata_rot;
  logic [31:0] w_rdata;

  // The aligner sees the live request while idle and the latched one afterwards.
  assign w_idle     = (r_state == ST_IDLE);
  assign w_off      = w_idle ? req_addr[1:0] : r_off;
  assign w_size     = w_idle ? req_size      : r_size;
  assign w_unsigned = w_idle ? req_unsigned  : r_unsigned;
  assign w_w0       = (r_state == ST_ACC1) ? r_w0 : mem_do;

  lsu_align u_align (
    .i_offset       (w_off),
    .i_size         (w_size),
    .i_unsigned     (w_unsigned),
    .i_wdata        (req_wdata),
    .i_w0           (w_w0),
    .i_w1           (mem_do),
    .o_mask0        (w_mask0),
    .o_mask1        (w_mask1),
    .o_misaligned   (w_misaligned),
    .o_size_illegal (w_size_ill),
    .o_wdata_rot    (w_wdata_rot),
    .o_rdata        (w_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_req_ready  <= 1'b1;
      r_we         <= 1'b0;
      r_off        <= 2'b00;
      r_size       <= 2'b00;
      r_unsigned   <= 1'b0;
      r_w0         <= 32'h0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'h0;
      r_resp_err   <= 1'b0;
      r_mem_a      <= 32'h0;
      r_mem_di     <= 32'h0;
      r_mem_m      <= 4'b0000;
      r_mem_we     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_we        <= req_we;
            r_off       <= req_addr[1:0];
            r_size      <= req_size;
            r_unsigned  <= req_unsigned;
            r_req_ready <= 1'b0;
            if (w_size_ill || (w_misaligned && !ALLOW_MISALIGNED)) begin
              r_state      <= ST_RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= 32'h0;
            end else begin
              r_state  <= ST_ACC0;
              r_mem_a  <= {req_addr[31:2], 2'b00};
              r_mem_we <= req_we;
              r_mem_m  <= req_we ? w_mask0 : 4'b0000;
              r_mem_di <= req_we ? w_wdata_rot : 32'h0;
            end
          end
        end
        ST_ACC0: begin
          r_w0 <= mem_do;
          if (w_misaligned) begin
            r_state <= ST_ACC1;
            r_mem_a <= r_mem_a + 32'd4;
            r_mem_m <= r_we ? w_mask1 : 4'b0000;
          end else begin
            r_state      <= ST_RESP;
            r_resp_valid <= 1'b1;
            r_resp_rdata <= r_we ? 32'h0 : w_rdata;
            r_mem_a      <= 32'h0;
            r_mem_di     <= 32'h0;
            r_mem_m      <= 4'b0000;
            r_mem_we     <= 1'b0;
          end
        end
        ST_ACC1: begin
          r_state      <= ST_RESP;
          r_resp_valid <= 1'b1;
          r_resp_rdata <= r_we ? 32'h0 : w_rdata;
          r_mem_a      <= 32'h0;
          r_mem_di     <= 32'h0;
          r_mem_m      <= 4'b0000;
          r_mem_we     <= 1'b0;
        end
        ST_RESP: begin
          if (resp_ready) begin
            r_state      <= ST_IDLE;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'h0;
            r_resp_err   <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign mem_a      = r_mem_a;
  assign mem_di     = r_mem_di;
  assign mem_m      = r_mem_m;
  assign mem_we     = r_mem_we;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// Module  : tb_load_store_unit
// Brief   : Scoreboard bench for load_store_unit (split and reject variants).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_load_store_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [1:0]  req_valid, req_ready, req_we, req_unsigned;
  logic [31:0] req_addr   [2];
  logic [1:0]  req_size   [2];
  logic [31:0] req_wdata  [2];
  logic [1:0]  resp_valid, resp_ready, resp_err, mem_we;
  logic [31:0] resp_rdata [2];
  logic [31:0] mem_a      [2];
  logic [31:0] mem_di     [2];
  logic [3:0]  mem_m      [2];
  logic [31:0] mem_do     [2];
  logic [31:0] ram [2][256];

  load_store_unit #(.ALLOW_MISALIGNED(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_size(req_size[0]), .req_unsigned(req_unsigned[0]),
    .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]), .mem_a(mem_a[0]),
    .mem_di(mem_di[0]), .mem_m(mem_m[0]), .mem_we(mem_we[0]), .mem_do(mem_do[0])
  );

  load_store_unit #(.ALLOW_MISALIGNED(1'b0)) dut_strict (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_size(req_size[1]), .req_unsigned(req_unsigned[1]),
    .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]), .mem_a(mem_a[1]),
    .mem_di(mem_di[1]), .mem_m(mem_m[1]), .mem_we(mem_we[1]), .mem_do(mem_do[1])
  );

  assign mem_do[0] = ram[0][mem_a[0][9:2]];
  assign mem_do[1] = ram[1][mem_a[1][9:2]];

  always @(posedge clk) begin
    for (int u = 0; u < 2; u++)
      if (mem_we[u])
        for (int b = 0; b < 4; b++)
          if (mem_m[u][b]) ram[u][mem_a[u][9:2]][8*b +: 8] = mem_di[u][8*b +: 8];
  end

  typedef struct {
    int          unit;
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   acc_cyc [2];
  int   first_cyc [2];
  bit   seen [2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Response monitor: pops the scoreboard on each handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int u = 0; u < 2; u++) begin
        if (resp_valid[u]) begin
          if (!seen[u]) begin
            seen[u] = 1'b1;
            first_cyc[u] = cyc;
          end
          if (resp_ready[u]) begin
            if (q.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL unexpected_resp: unit %0d got response, none expected", u);
            end else begin
              exp_t e;
              e = q.pop_front();
              chk("resp_unit", u, e.unit);
              chk("resp_rdata", resp_rdata[u], e.rdata);
              chk("resp_err", {31'b0, resp_err[u]}, {31'b0, e.err});
              chk("resp_latency", first_cyc[u] - acc_cyc[u], e.lat);
            end
            seen[u] = 1'b0;
          end
        end
      end
    end
  end

  task automatic issue(input int u, input logic we, input logic [31:0] addr,
                       input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                       input bit push, input logic [31:0] erd, input logic eerr, input int elat);
    int n = 0;
    while (!req_ready[u] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready[u]) chk("req_ready_timeout", 32'd0, 32'd1);
    if (push) q.push_back('{u, erd, eerr, elat});
    acc_cyc[u]      = cyc;
    req_we[u]       = we;
    req_addr[u]     = addr;
    req_size[u]     = size;
    req_unsigned[u] = uns;
    req_wdata[u]    = wdata;
    req_valid[u]    = 1'b1;
    @(posedge clk); #1;
    req_valid[u]    = 1'b0;
  endtask

  task automatic wait_done(input int u);
    int n = 0;
    while ((q.size() != 0 || !req_ready[u]) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (q.size() != 0 || !req_ready[u]) chk("resp_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < 256; i++) ram[u][i] = 32'h0;
      req_addr[u] = 32'h0; req_size[u] = 2'b00; req_wdata[u] = 32'h0;
      seen[u] = 1'b0; acc_cyc[u] = 0; first_cyc[u] = 0;
    end
    req_valid = 2'b00; req_we = 2'b00; req_unsigned = 2'b00; resp_ready = 2'b11;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'b0, req_ready[0]}, 32'd1);
    chk("rst_resp_valid", {30'b0, resp_valid}, 32'd0);
    chk("rst_mem_a", mem_a[0], 32'h0);
    chk("rst_mem_m_we", {27'b0, mem_m[0], mem_we[0]}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Aligned word store.
    issue(0, 1'b1, 32'h100, 2'b10, 1'b0, 32'hDEADBEEF, 1, 32'h0, 1'b0, 2);
    chk("st_w_acc0_a", mem_a[0], 32'h100);
    chk("st_w_acc0_m", {28'b0, mem_m[0]}, 32'hF);
    chk("st_w_acc0_di", mem_di[0], 32'hDEADBEEF);
    chk("st_w_acc0_we", {31'b0, mem_we[0]}, 32'd1);
    wait_done(0);
    chk("st_w_ram", ram[0][64], 32'hDEADBEEF);

    // Byte and halfword loads, signed and unsigned.
    ram[0][64] = 32'h80FFFFFF;
    issue(0, 1'b0, 32'h103, 2'b00, 1'b0, 32'h0, 1, 32'hFFFFFF80, 1'b0, 2);
    chk("ld_b_acc0_we_m", {27'b0, mem_m[0], mem_we[0]}, 32'h0);
    issue(0, 1'b0, 32'h103, 2'b00, 1'b1, 32'h0, 1, 32'h00000080, 1'b0, 2);
    issue(0, 1'b0, 32'h102, 2'b01, 1'b0, 32'h0, 1, 32'hFFFF80FF, 1'b0, 2);
    issue(0, 1'b0, 32'h102, 2'b01, 1'b1, 32'h0, 1, 32'h000080FF, 1'b0, 2);
    wait_done(0);

    // Word store crossing 0x100.
    issue(0, 1'b1, 32'h0FE, 2'b10, 1'b0, 32'h11223344, 1, 32'h0, 1'b0, 3);
    chk("st_mis_acc0_a", mem_a[0], 32'h0FC);
    chk("st_mis_acc0_m", {28'b0, mem_m[0]}, 32'hC);
    chk("st_mis_acc0_di", mem_di[0], 32'h33441122);
    @(posedge clk); #1;
    chk("st_mis_acc1_a", mem_a[0], 32'h100);
    chk("st_mis_acc1_m", {28'b0, mem_m[0]}, 32'h3);
    chk("st_mis_acc1_we", {31'b0, mem_we[0]}, 32'd1);
    wait_done(0);
    chk("st_mis_ram0", ram[0][63], 32'h33440000);
    chk("st_mis_ram1", ram[0][64], 32'h80FF1122);

    issue(0, 1'b0, 32'h0FE, 2'b10, 1'b0, 32'h0, 1, 32'h11223344, 1'b0, 3);
    issue(0, 1'b0, 32'h0FF, 2'b01, 1'b0, 32'h0, 1, 32'h00002233, 1'b0, 3);
    issue(0, 1'b0, 32'h100, 2'b11, 1'b0, 32'h0, 1, 32'h0, 1'b1, 1);
    chk("ill_no_we", {31'b0, mem_we[0]}, 32'd0);
    wait_done(0);

    // Wrapping load, response held with resp_ready low.
    ram[0][255] = 32'hCAFE0000;
    ram[0][0]   = 32'h0000BABE;
    resp_ready[0] = 1'b0;
    issue(0, 1'b0, 32'hFFFFFFFE, 2'b10, 1'b0, 32'h0, 1, 32'hBABECAFE, 1'b0, 3);
    chk("wrap_acc0_a", mem_a[0], 32'hFFFFFFFC);
    @(posedge clk); #1;
    chk("wrap_acc1_a", mem_a[0], 32'h0);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", {31'b0, resp_valid[0]}, 32'd1);
      chk("hold_rdata", resp_rdata[0], 32'hBABECAFE);
      chk("hold_req_ready", {31'b0, req_ready[0]}, 32'd0);
      @(posedge clk); #1;
    end
    resp_ready[0] = 1'b1;
    wait_done(0);

    // Reset landing in ACC1 of a split store.
    ram[0][63] = 32'h12345678;
    ram[0][64] = 32'h9ABCDEF0;
    issue(0, 1'b1, 32'h0FE, 2'b10, 1'b0, 32'hAABBCCDD, 0, 32'h0, 1'b0, 0);
    @(posedge clk); #1;
    chk("rstacc1_we_before", {31'b0, mem_we[0]}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstacc1_we", {31'b0, mem_we[0]}, 32'd0);
    chk("rstacc1_a", mem_a[0], 32'h0);
    chk("rstacc1_m_di", {mem_m[0], mem_di[0][27:0]}, 32'h0);
    chk("rstacc1_valid_ready", {30'b0, resp_valid[0], req_ready[0]}, 32'd1);
    @(posedge clk); #1;
    seen[0] = 1'b0; seen[1] = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rstacc1_ram0", ram[0][63], 32'hCCDD5678);
    chk("rstacc1_ram1", ram[0][64], 32'h9ABCDEF0);

    // Strict unit: misaligned and illegal accesses rejected without RAM traffic.
    ram[1][64] = 32'h01020304;
    issue(1, 1'b0, 32'h103, 2'b01, 1'b0, 32'h0, 1, 32'h0, 1'b1, 1);
    chk("strict_mis_we", {31'b0, mem_we[1]}, 32'd0);
    chk("strict_mis_a", mem_a[1], 32'h0);
    wait_done(1);
    issue(1, 1'b1, 32'h100, 2'b11, 1'b0, 32'hFFFFFFFF, 1, 32'h0, 1'b1, 1);
    chk("strict_ill_we", {31'b0, mem_we[1]}, 32'd0);
    wait_done(1);
    chk("strict_ram_intact", ram[1][64], 32'h01020304);
    issue(1, 1'b0, 32'h100, 2'b10, 1'b0, 32'h0, 1, 32'h01020304, 1'b0, 2);
    issue(1, 1'b0, 32'h101, 2'b00, 1'b1, 32'h0, 1, 32'h00000003, 1'b0, 2);
    wait_done(1);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: ALLOW_MISALIGNED, default 1, 1 = split word-crossing accesses into two, 0 = reject them with resp_err.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  1  core access request present.
REQ-005 req_ready  output  1  unit can accept a request.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_addr  input  32  byte address.
REQ-008 req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-009 req_unsigned  input  1  load zero-extend (1) / sign-extend (0).
REQ-010 req_wdata  input  32  store data, right-justified.
REQ-011 resp_valid  output  1  response present.
REQ-012 resp_ready  input  1  core accepts response.
REQ-013 resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-014 resp_err  output  1  illegal size or rejected misaligned access.
REQ-015 mem_a  output  32  word-aligned RAM address (bits [1:0] = 00).
REQ-016 mem_di  output  32  RAM write data, lane-positioned.
REQ-017 mem_m  output  4  RAM byte-lane write mask.
REQ-018 mem_we  output  1  RAM write enable.
REQ-019 mem_do  input  32  RAM read data, combinational from mem_a (same cycle).

Function
REQ-020 FSM states IDLE, ACC0, ACC1, RESP; req_ready SHALL be 1 only in IDLE.
REQ-021 IDLE: on req_valid, latch all req_* fields; legal -> ACC0; illegal size or (misaligned and ALLOW_MISALIGNED=0) -> RESP with resp_err=1, no RAM access.
REQ-022 Offset o=addr[1:0], n=1/2/4 bytes; access misaligned iff o+n>4; occupied lanes o..o+n-1, lanes >=4 map to second word at lane-4.
REQ-023 ACC0: mem_a={addr[31:2],2'b00}; ACC1: mem_a=ACC0 address+4, wrapping 0xFFFFFFFC -> 0x00000000.
REQ-024 Store: mem_di=wdata rotated left by 8*o in both ACC states; mem_m=lanes 0..3 in ACC0, overflow lanes in ACC1; mem_we=1 in ACC states only.
REQ-025 Load: mem_we=0, mem_m=0; mem_do captured at end of ACC0 (w0) and ACC1 (w1); data = low 32 bits of {w1,w0}>>8*o, then extended per size/unsigned.
REQ-026 Outside ACC states mem_we=0, mem_m=0, mem_di=0, mem_a=0.
REQ-027 ACC0 -> ACC1 if misaligned, else RESP; ACC1 -> RESP.
REQ-028 Latency from accept edge: aligned resp_valid 2 cycles later, misaligned 3, error 1.
REQ-029 RESP: resp_valid=1, resp_rdata/resp_err stable until resp_valid&&resp_ready, then -> IDLE; new request not accepted in the same cycle.

Reset
REQ-030 rst_n low SHALL immediately force IDLE, resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, mem_m=0, mem_a=0, mem_di=0.
REQ-031 Reset during ACC1 of a store SHALL abort the second write; the ACC0 write already committed remains (no rollback).

Structure
REQ-032 Shared package lsu_pkg SHALL hold size encodings and the FSM state enum.
REQ-033 One combinational sub-module lsu_align SHALL compute lane masks, store rotation and load merge/extension; FSM and registers stay in load_store_unit.

Verification
REQ-034 Aligned word store addr 0x100, wdata 0xDEADBEEF -> ACC0 mem_a=0x100, mem_m=1111, mem_di=0xDEADBEEF; resp 2 cycles later, rdata 0.
REQ-035 Byte load signed addr 0x103, RAM[0x100]=0x80FFFFFF -> rdata 0xFFFFFF80; same unsigned -> 0x00000080.
REQ-036 Misaligned word store addr 0x0FE, wdata 0x11223344 -> ACC0 mem_a=0x0FC, m=1100, di=0x33441122; ACC1 mem_a=0x100, m=0011; resp 3 cycles later.
REQ-037 ALLOW_MISALIGNED=0, halfword load addr 0x103 -> no mem_we/mem_a activity, resp_err=1 next cycle, rdata 0; size=11 -> same error.
REQ-038 Misaligned word load at 0xFFFFFFFE -> second access mem_a=0x00000000; resp held 5 cycles with resp_ready=0, stable; rst_n pulse in ACC1 of store -> only first-word write visible.
